hour_disp_driver: RTL
=====================

# hour_disp_driver

Downstream consumer of the mod-24 hour counter. Captures a 0–23 hour value on a load strobe and optionally remaps it to 12-hour form with a PM flag. Converts the value to two BCD digits with a small subtract-by-ten state machine. Drives a 2-digit, time-multiplexed, active-low 7-segment display with leading-zero blanking.

## Interface
- SCAN_DIV, default 4: clk cycles per digit dwell; legal values ≥2.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- hour_in  in  5  hour value, binary; legal range 0–23.
- hour_load  in  1  single-cycle strobe; samples hour_in and mode_12h.
- mode_12h  in  1  1 = display in 12-hour form, 0 = 24-hour form.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  2  digit enables, active-low; an[0] = ones digit, an[1] = tens digit.
- pm  out  1  1 when the last valid hour was ≥12.
- busy  out  1  high while conversion is in progress.
- err  out  1  1 when the last load had hour_in > 23.

## Operation
- **Reset values:** seg=1000000 (digit 0), an=10, pm=0, busy=0, err=0. Internal state after reset:
  - state=IDLE, tens_q=0, ones_q=0;
  - sel=0, div_cnt=0.
- **IDLE state:**
  - If hour_load=1 and hour_in ≤ 23:
    - err←0;
    - pm←(hour_in ≥ 12);
    - work←mapped value, tens_acc←0, busy←1;
    - go to CONV.
  - If hour_load=1 and hour_in > 23: err←1. tens_q, ones_q and pm keep their values, busy stays 0, state stays IDLE.
- **12-hour mapping** (only when mode_12h=1): 0→12; 13–23→hour−12; 1–12 unchanged. In 24-hour form the value is used unchanged.
- **CONV state, one step per cycle:**
  - If work ≥ 10: work←work−10, tens_acc←tens_acc+1.
  - Otherwise: tens_q←tens_acc, ones_q←work (4-bit each), busy←0, go to IDLE.
- **hour_load while busy:** ignored. No capture, and err does not change.
- **Scan logic (free-running):**
  - div_cnt counts 0..SCAN_DIV−1, then wraps to 0.
  - On the wrap cycle, sel toggles.
- **Output registers** (update every cycle from the current sel, tens_q, ones_q):
  - sel=0: an←10, seg←encode(ones_q).
  - sel=1: an←01, seg←(tens_q==0 ? 1111111 : encode(tens_q)).
- **Segment encoding:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Reset during CONV:** the conversion is abandoned and all reset values apply on the next cycle.

## Timing
- Let E0 be the edge that samples hour_load=1 with a valid hour.
  - busy=1 from E0.
  - tens_q, ones_q update and busy falls at edge E(T+1), where T = mapped/10. Latency is 1–3 cycles after E0.
  - pm updates at E0.
- err updates at the edge sampling an invalid load.
- seg/an lag sel, tens_q and ones_q by exactly one cycle.
- Scan period: each digit is shown for SCAN_DIV cycles, so a full refresh takes 2·SCAN_DIV cycles.
- pm, err, busy, seg and an are all registered outputs; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold rst for 3 cycles, then release → seg=1000000, an=10, pm=busy=err=0. With SCAN_DIV=4, an alternates 10/01 every 4 cycles; during an=01, seg=1111111 (tens is blanked).
- **24-hour load:** load 17 with mode_12h=0 → busy high for 2 cycles; tens_q=1, ones_q=7, pm=1. Display shows seg 1111001 when an=01 and 1111000 when an=10.
- **12-hour mapping:**
  - load 0 → displays 12, pm=0;
  - load 23 → displays 11, pm=1;
  - load 12 → displays 12, pm=1.
- **Invalid load:** load 24 after a valid 17 → err=1, busy stays 0, display still shows 17. A following load of 5 → err=0, display shows 5 with the tens digit blanked, busy high for exactly 1 cycle.
- **Load during conversion:** load 23 (mode 0), then pulse hour_load with 4 on the next cycle → the second strobe is ignored and the display shows 23.
- **Reset mid-conversion:** assert rst one cycle after loading 19 → state returns to IDLE, digits 0/0, busy=0, pm=0.

Source files
------------

// File: rtl/hour_disp_driver.sv
// Hour display driver: captures a 0-23 hour, optionally folds it to 12-hour form,
// splits it into BCD digits by repeated subtraction and scans a 2-digit active-low 7-segment display.
//
// state | meaning
// IDLE  | waiting for hour_load; digits hold the last converted value
// CONV  | subtracting ten per cycle from work, counting tens in tens_acc
module hour_disp_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour_in,
  input  logic       hour_load,
  input  logic       mode_12h,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       pm,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state, state_nxt;
  logic [4:0]    work;
  logic [1:0]    tens_acc;
  logic [3:0]    tens_q, ones_q;
  logic [4:0]    mapped;
  logic          load_ok, load_bad, work_ge10;
  logic          sel;
  logic [CW-1:0] div_cnt;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b1111111;
    endcase
  endfunction

  // 12-hour fold: midnight shows as 12, afternoon hours drop by 12
  always_comb begin
    mapped = hour_in;
    if (mode_12h) begin
      if (hour_in == 5'd0)
        mapped = 5'd12;
      else if (hour_in > 5'd12)
        mapped = hour_in - 5'd12;
    end
  end

  assign load_ok   = (state == IDLE) && hour_load && (hour_in <= 5'd23);
  assign load_bad  = (state == IDLE) && hour_load && (hour_in > 5'd23);
  assign work_ge10 = (work >= 5'd10);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_ok) state_nxt = CONV;
      CONV:    if (!work_ge10) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      tens_acc <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      pm       <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (load_ok) begin
        err      <= 1'b0;
        pm       <= (hour_in >= 5'd12);
        work     <= mapped;
        tens_acc <= '0;
      end else if (load_bad) begin
        err <= 1'b1;
      end
      if (state == CONV) begin
        if (work_ge10) begin
          work     <= work - 5'd10;
          tens_acc <= tens_acc + 2'd1;
        end else begin
          tens_q <= {2'b00, tens_acc};
          ones_q <= work[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sel     <= 1'b0;
    end else if (div_cnt == CW'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      sel     <= ~sel;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Tens digit is blanked when zero
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 2'b10;
      seg <= 7'b1000000;
    end else if (!sel) begin
      an  <= 2'b10;
      seg <= encode(ones_q);
    end else begin
      an  <= 2'b01;
      seg <= (tens_q == 4'd0) ? 7'b1111111 : encode(tens_q);
    end
  end

endmodule
